// File: rtl/ram_seq_ctrl.sv
// rtl/ram_seq_ctrl.sv - fill/scan sequencer driving a single-port RAM; optional readback check under RAM_SEQ_VERIFY_EN
module ram_seq_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int RATE_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_fill,
  input  logic              start_scan,
  input  logic              stop,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

`ifdef RAM_SEQ_VERIFY_EN
  typedef enum logic [1:0] {IDLE, FILL, SCAN, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;
`endif

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic              wren_n;
  logic              done_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              mode_q, mode_n;
  logic [DATA_W-1:0] base_q, base_n;

`ifdef RAM_SEQ_VERIFY_EN
  logic              err_q, err_n;
  logic [ADDR_W-1:0] err_addr_q, err_addr_n;
  logic [ADDR_W:0]   vcnt, vcnt_n;
  logic [ADDR_W-1:0] prev_addr;
`endif

  // Pattern word for an address; sum is truncated to DATA_W so it wraps naturally
  function automatic logic [DATA_W-1:0] pattern(input logic mode,
                                                input logic [DATA_W-1:0] base,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] a_t;
    a_t = DATA_W'(a);
    return mode ? base + a_t : base;
  endfunction

  assign busy = (state != IDLE);

`ifdef RAM_SEQ_VERIFY_EN
  assign error    = err_q;
  assign err_addr = err_addr_q;
`else
  assign error    = 1'b0;
  assign err_addr = '0;
  logic unused_q;
  assign unused_q = ^ram_q;
`endif

  // Next-state and next registered-output logic; stop overrides every request
  always_comb begin
    state_n = state;
    addr_n  = ram_address;
    data_n  = ram_data;
    wren_n  = 1'b0;
    done_n  = 1'b0;
    cnt_n   = cnt;
    mode_n  = mode_q;
    base_n  = base_q;
`ifdef RAM_SEQ_VERIFY_EN
    err_n      = err_q;
    err_addr_n = err_addr_q;
    vcnt_n     = vcnt;
`endif
    case (state)
      IDLE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start_fill) begin
          state_n = FILL;
          addr_n  = '0;
          wren_n  = 1'b1;
          data_n  = pattern(fill_mode, fill_value, '0);
          mode_n  = fill_mode;
          base_n  = fill_value;
`ifdef RAM_SEQ_VERIFY_EN
          err_n      = 1'b0;
          err_addr_n = '0;
`endif
        end else if (start_scan) begin
          state_n = SCAN;
          addr_n  = '0;
          cnt_n   = '0;
        end
      end
      FILL: begin
        if (stop) begin
          state_n = IDLE;
        end else if (ram_address == ADDR_LAST) begin
`ifdef RAM_SEQ_VERIFY_EN
          state_n = VERIFY;
          addr_n  = '0;
          vcnt_n  = '0;
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end else begin
          addr_n = ram_address + 1'b1;
          data_n = pattern(mode_q, base_q, addr_n);
          wren_n = 1'b1;
        end
      end
      SCAN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          cnt_n  = '0;
          addr_n = ram_address + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef RAM_SEQ_VERIFY_EN
      VERIFY: begin
        if (stop) begin
          state_n = IDLE;
        end else begin
          // ram_q in this cycle belongs to the address presented one cycle earlier
          if ((vcnt != '0) && !err_q &&
              (ram_q != pattern(mode_q, base_q, prev_addr))) begin
            err_n      = 1'b1;
            err_addr_n = prev_addr;
          end
          if (vcnt[ADDR_W]) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            vcnt_n = vcnt + 1'b1;
            if (ram_address != ADDR_LAST) begin
              addr_n = ram_address + 1'b1;
            end
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      mode_q      <= 1'b0;
      base_q      <= '0;
    end else begin
      state       <= state_n;
      ram_address <= addr_n;
      ram_data    <= data_n;
      ram_wren    <= wren_n;
      done        <= done_n;
      cnt         <= cnt_n;
      mode_q      <= mode_n;
      base_q      <= base_n;
    end
  end

`ifdef RAM_SEQ_VERIFY_EN
  // Readback bookkeeping: sticky error, first failing address, delayed address
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
      vcnt       <= '0;
      prev_addr  <= '0;
    end else begin
      err_q      <= err_n;
      err_addr_q <= err_addr_n;
      vcnt       <= vcnt_n;
      prev_addr  <= ram_address;
    end
  end
`endif

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Sequencer that sits directly upstream of the 32x4 single-port RAM and drives its address, data and write-enable pins in place of the switches.
- FILL mode writes a constant or incrementing pattern to every word at one word per clock.
- SCAN mode steps through the addresses at a divided rate so that each word's contents can be viewed on the hex displays.
- The current address is exported for the address hex digits.

Parameters:
- ADDR_W, 5, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM data width.
- RATE_DIV, 50000000, clocks per SCAN step (1 Hz at 50 MHz); must be >= 1; benches use 4.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_fill  in  1  level-sampled request to begin FILL.
- start_scan  in  1  level-sampled request to begin SCAN.
- stop  in  1  abort FILL or SCAN and return to IDLE.
- fill_mode  in  1  0 = constant fill_value; 1 = fill_value + address (mod 2**DATA_W).
- fill_value  in  DATA_W  base fill pattern.
- ram_q  in  DATA_W  RAM read data (used only with VERIFY_EN).
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a sequence completes normally.
- error  out  1  sticky mismatch flag (VERIFY_EN only).
- err_addr  out  ADDR_W  address of the first mismatch (VERIFY_EN only).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - ram_address = 0, ram_data = 0, ram_wren = 0.
  - busy = 0, done = 0, error = 0, err_addr = 0.
  - Rate counter = 0.
- Reset mid-operation: at the next edge every output takes its reset value. No further writes occur.
- States: IDLE, FILL, SCAN, VERIFY (VERIFY exists only with VERIFY_EN).
- IDLE:
  - ram_wren = 0; ram_address holds its last value.
  - If start_fill = 1 at an edge, go to FILL.
  - Otherwise, if start_scan = 1, go to SCAN.
  - If both are asserted, FILL wins.
- FILL:
  - Entering edge sets ram_address = 0, ram_wren = 1, and ram_data = pattern(0).
  - Each subsequent edge increments ram_address and updates ram_data = pattern(addr).
  - The RAM captures one word per clock, so the first write happens in the cycle after start_fill is sampled.
  - After the cycle that presents address DEPTH-1:
    - ram_wren = 0.
    - Without VERIFY_EN: done pulses and the state returns to IDLE. FILL takes exactly DEPTH cycles with wren high.
    - With VERIFY_EN: go to VERIFY.
  - fill_value and fill_mode are sampled once on entry and held internally; later changes have no effect.
  - Pattern arithmetic is truncated to DATA_W (for example 0xF + 1 = 0x0).
- SCAN:
  - Entering edge sets ram_address = 0, ram_wren = 0, and clears the rate counter.
  - The rate counter counts 0..RATE_DIV-1. On terminal count, ram_address increments.
  - Address wraps from DEPTH-1 to 0.
  - Runs until stop; no done pulse.
- stop:
  - In FILL, SCAN or VERIFY: next state IDLE, ram_wren = 0, no done pulse.
  - stop has priority over all other inputs except reset.
- While busy, start_fill and start_scan are ignored.
- ram_data is held at its last value outside FILL.

Optional Feature:
- Macro: RAM_SEQ_VERIFY_EN.
- Defined:
  - FILL is followed by VERIFY, a readback of all DEPTH addresses with wren = 0.
  - ram_address = A driven in cycle k is registered by the RAM at the end of cycle k, and ram_q for A is valid in cycle k+1.
  - The controller compares ram_q against pattern(A) at the end of cycle k+1, using a one-deep delayed-address register.
  - VERIFY lasts DEPTH+1 cycles, then done pulses and the state returns to IDLE.
  - On the first mismatch, error = 1 and err_addr = A. Later mismatches do not change err_addr.
  - error clears only on reset or on entry to a new FILL.
- Undefined:
  - No VERIFY state; ram_q is ignored.
  - error and err_addr are tied to 0.

Test Plan:
- Reset mid-FILL: reset=1 at cycle 5 of FILL -> next edge ram_wren=0, ram_address=0, busy=0; no further writes.
- Constant fill: start_fill with fill_mode=0 and fill_value=0xA -> 32 consecutive cycles of wren=1 at addresses 0..31 with data 0xA, then a done pulse one cycle after address 31 (no VERIFY). A behavioural RAM model holds 0xA in every word.
- Incrementing fill: fill_mode=1, fill_value=0xE -> addr0=0xE, addr1=0xF, addr2=0x0, addr31=0xD (wrap check). fill_value changed mid-FILL has no effect.
- Scan with RATE_DIV=4, started from IDLE:
  - ram_address = 0,1,2… changing every 4 clocks, wrapping 31 -> 0; wren stays 0.
  - stop during SCAN -> IDLE with no done pulse.
- Simultaneous requests: start_fill=1 and start_scan=1 in the same IDLE cycle -> FILL entered. start_scan during FILL is ignored.
- VERIFY_EN defined, model RAM forced to corrupt address 7 and address 20:
  - error=1 and err_addr=7; done pulses after 32+1 verify cycles.
  - A clean second FILL clears error.
